fft_seq_ctrl: RTL and testbench
===============================

Name: fft_seq_ctrl

Overview:
- Sequencer for the in-place radix-2 DIT FFT datapath: loads N samples into the working RAM in bit-reversed order, then issues every butterfly of every stage with operand and twiddle addresses, then streams results out in natural order.
- Sits between the input stream, the sample RAM, the butterfly pipeline and the output stream.
- Replaces combinational stage/done decoding with a clocked FSM, counters and handshakes.

Parameters:
- N_LOG2, 3, log2 of FFT length N (N = 2**N_LOG2, stages 0..N_LOG2-1).
- BF_LAT, 2, butterfly pipeline latency in cycles, from issue to RAM write-back.
- SW, derived = max(1,$clog2(N_LOG2)), stage index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin one FFT frame; sampled only in IDLE.
- in_valid  in  1  input sample present.
- in_ready  out  1  high only in LOAD.
- in_wr_en  out  1  RAM write strobe = in_valid & in_ready.
- in_wr_addr  out  N_LOG2  bit-reversed load index.
- bf_valid  out  1  butterfly issue strobe.
- bf_addr_a  out  N_LOG2  upper operand address.
- bf_addr_b  out  N_LOG2  lower operand address.
- bf_tw_addr  out  N_LOG2-1  twiddle ROM index (width min 1).
- stage  out  SW  current stage index.
- busy  out  1  high in every state except IDLE.
- out_ready  in  1  downstream accepts a read.
- out_rd_en  out  1  RAM read strobe = out_ready in OUTPUT.
- out_rd_addr  out  N_LOG2  natural-order read index.
- out_last  out  1  with out_rd_en on index N-1.
- fft_done  out  1  one-cycle pulse after last read.

Behaviour:
- Reset: async to IDLE. All counters are 0 and all outputs are 0.
- FSM states are IDLE, LOAD, COMPUTE, DRAIN, OUTPUT and DONE.
- IDLE: when start=1, go to LOAD with cnt=0.
- LOAD: each accept writes in_wr_addr = bitrev(cnt) and increments cnt. The Nth accept goes to COMPUTE with stage=0 and j=0. in_valid=0 holds state.
- COMPUTE: bf_valid=1 every cycle with no stall. j runs 0..N/2-1, with half=2**s, pos=j&(half-1), grp=j>>s:
  - a = grp*2*half + pos
  - b = a + half
  - tw = pos << (N_LOG2-1-s)
  - After j=N/2-1, go to DRAIN.
- DRAIN: hold BF_LAT cycles with bf_valid=0. This prevents read-before-write hazards across stages. Then go to COMPUTE with stage+1, or to OUTPUT if stage=N_LOG2-1.
- Compute time is N_LOG2*(N/2+BF_LAT) cycles.
- OUTPUT: out_rd_addr=cnt, and cnt increments on out_ready. out_ready=0 stalls the read with address held. The read at N-1 asserts out_last and moves to DONE.
- DONE: fft_done=1 for one cycle, then IDLE. start in DONE is ignored.
- start outside IDLE is ignored. in_valid outside LOAD is ignored (in_ready=0).
- Counters wrap only via state transitions; there is no modulo overflow path.

Optional Feature:
- Macro FFT_BFP_SCALE_EN enables block-floating-point scaling.
- With it, the block adds:
  - input ovf_in (1), the butterfly overflow flag;
  - output bf_scale (1), halve the outputs of the current stage;
  - output blk_exp (SW+1), the count of scaled stages.
- Behaviour with it:
  - Any ovf_in=1 during COMPUTE/DRAIN of stage s sets a sticky flag.
  - At the DRAIN to COMPUTE transition, bf_scale takes the flag for stage s+1, the flag clears, and blk_exp increments if the flag was set.
  - Stage 0 has bf_scale=0.
  - blk_exp clears on IDLE to LOAD and holds through OUTPUT.
  - Overflow in the last stage is reported only in blk_exp? No: it is dropped. It only sets the sticky flag, which is discarded.
- Without the macro, the ports are absent and no scaling is done.

Decomposition:
- Package fft_pkg holds:
  - state enum fft_seq_state_t;
  - a bitrev function;
  - localparams N, HALF_N and SW derivation.
- Sub-module fft_bf_addr_gen: combinational (stage, j) to (a, b, tw), unit-testable on its own.

Test Plan:
- Reset mid-COMPUTE (N=8, BF_LAT=2), reset high for 1 cycle -> state IDLE; bf_valid, busy and in_ready are 0 asynchronously.
- Load 8 samples back-to-back -> in_wr_addr sequence 0,4,2,6,1,5,3,7. COMPUTE starts the cycle after the 8th accept.
- Address check:
  - stage 1 j=3 -> a=5, b=7, tw=2;
  - stage 2 j=2 -> a=2, b=6, tw=2;
  - stage 0 j=1 -> a=2, b=3, tw=0.
  - Compute span is exactly 18 cycles.
- Output with out_ready toggling 1,0,1,... -> addresses 0..7 each read once, held during stalls. out_last is on address 7 and fft_done pulses the next cycle.
- start asserted during LOAD and during DONE -> ignored; exactly one frame runs.
- With FFT_BFP_SCALE_EN, ovf_in pulse in stage 0 -> bf_scale=1 throughout stage 1 and blk_exp=1. No overflow in stage 1 -> bf_scale=0 in stage 2.

Source files
------------

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the radix-2 DIT FFT sequencer:
//   fft_seq_state_t : sequencer FSM states
//   calc_sw/calc_jw : stage-index and butterfly-index width derivation
//   bitrev          : low nbits of v in reversed order (load addressing)
//   N, HALF_N, SW   : values for the default FFT length (N_LOG2_DEF)
// ---------------------------------------------------------------------------
package fft_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_COMPUTE = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_OUTPUT  = 3'd4,
      ST_DONE    = 3'd5
   } fft_seq_state_t;

   // Stage index width: max(1, clog2(n_log2)).
   function automatic int unsigned calc_sw(input int unsigned n_log2);
      return ($clog2(n_log2) < 1) ? 1 : $clog2(n_log2);
   endfunction

   // Butterfly-index / twiddle-index width: max(1, n_log2-1).
   function automatic int unsigned calc_jw(input int unsigned n_log2);
      return (n_log2 > 1) ? n_log2 - 1 : 1;
   endfunction

   // Reverses the low nbits of v; higher result bits are zero.
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned nbits);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < nbits) begin
            r = (r << 1) | ((v >> i) & 32'd1);
         end
      end
      return r;
   endfunction

   localparam int unsigned N_LOG2_DEF = 3;
   localparam int unsigned N          = 2 ** N_LOG2_DEF;
   localparam int unsigned HALF_N     = N / 2;
   localparam int unsigned SW         = calc_sw(N_LOG2_DEF);

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// fft_seq_ctrl_if
// Bundles the sequencer's control, load, butterfly-issue and read-out
// signals. Modport master is the sequencer, modport slave is its environment.
//   start/busy/fft_done          : frame control
//   in_valid/in_ready/in_wr_*    : input stream and RAM write port
//   bf_valid/bf_addr_*/bf_tw_addr/stage : butterfly issue
//   out_ready/out_rd_*/out_last  : RAM read port and output stream
// Build option FFT_BFP_SCALE_EN adds ovf_in, bf_scale and blk_exp.
// ---------------------------------------------------------------------------
interface fft_seq_ctrl_if import fft_pkg::*; #(
   parameter int unsigned N_LOG2 = N_LOG2_DEF
);
   localparam int unsigned STW = calc_sw(N_LOG2);
   localparam int unsigned JW  = calc_jw(N_LOG2);

   logic              start;
   logic              busy;
   logic              fft_done;

   logic              in_valid;
   logic              in_ready;
   logic              in_wr_en;
   logic [N_LOG2-1:0] in_wr_addr;

   logic              bf_valid;
   logic [N_LOG2-1:0] bf_addr_a;
   logic [N_LOG2-1:0] bf_addr_b;
   logic [JW-1:0]     bf_tw_addr;
   logic [STW-1:0]    stage;

   logic              out_ready;
   logic              out_rd_en;
   logic [N_LOG2-1:0] out_rd_addr;
   logic              out_last;

`ifdef FFT_BFP_SCALE_EN
   logic              ovf_in;
   logic              bf_scale;
   logic [STW:0]      blk_exp;

   modport master (
      input  start, in_valid, out_ready, ovf_in,
      output busy, fft_done, in_ready, in_wr_en, in_wr_addr,
             bf_valid, bf_addr_a, bf_addr_b, bf_tw_addr, stage,
             out_rd_en, out_rd_addr, out_last, bf_scale, blk_exp
   );
   modport slave (
      output start, in_valid, out_ready, ovf_in,
      input  busy, fft_done, in_ready, in_wr_en, in_wr_addr,
             bf_valid, bf_addr_a, bf_addr_b, bf_tw_addr, stage,
             out_rd_en, out_rd_addr, out_last, bf_scale, blk_exp
   );
`else
   modport master (
      input  start, in_valid, out_ready,
      output busy, fft_done, in_ready, in_wr_en, in_wr_addr,
             bf_valid, bf_addr_a, bf_addr_b, bf_tw_addr, stage,
             out_rd_en, out_rd_addr, out_last
   );
   modport slave (
      output start, in_valid, out_ready,
      input  busy, fft_done, in_ready, in_wr_en, in_wr_addr,
             bf_valid, bf_addr_a, bf_addr_b, bf_tw_addr, stage,
             out_rd_en, out_rd_addr, out_last
   );
`endif

endinterface

// File: rtl/fft_bf_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_bf_addr_gen
// Combinational butterfly address generator for an in-place radix-2 DIT FFT.
//   stage : stage index s
//   j     : butterfly index within the stage, 0..N/2-1
//   a     : upper operand address = grp*2*half + pos  (half = 2**s)
//   b     : lower operand address = a + half
//   tw    : twiddle index = pos << (N_LOG2-1-s)
// ---------------------------------------------------------------------------
module fft_bf_addr_gen import fft_pkg::*; #(
   parameter  int unsigned N_LOG2 = N_LOG2_DEF,
   localparam int unsigned STW    = calc_sw(N_LOG2),
   localparam int unsigned JW     = calc_jw(N_LOG2)
) (
   input  logic [STW-1:0]    stage,
   input  logic [JW-1:0]     j,
   output logic [N_LOG2-1:0] a,
   output logic [N_LOG2-1:0] b,
   output logic [JW-1:0]     tw
);

   logic [N_LOG2-1:0] jx;
   logic [N_LOG2-1:0] half;
   logic [N_LOG2-1:0] mask;
   logic [N_LOG2-1:0] pos;
   logic [N_LOG2-1:0] tw_full;
   logic [STW-1:0]    tw_shift;

   // grp*2*half is the group bits of j moved up by one position, so the
   // address is formed by masking and shifting instead of multiplying.
   always_comb begin
      jx       = N_LOG2'(j);
      half     = N_LOG2'(1) << stage;
      mask     = half - N_LOG2'(1);
      pos      = jx & mask;
      a        = ((jx & ~mask) << 1) | pos;
      b        = a | half;
      tw_shift = STW'(N_LOG2 - 1) - stage;
      tw_full  = pos << tw_shift;
      tw       = JW'(tw_full);
   end

endmodule

// File: rtl/fft_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fft_seq_ctrl
// Sequencer for an in-place radix-2 DIT FFT: loads N samples in bit-reversed
// order, issues every butterfly of every stage (with a BF_LAT drain gap
// between stages), then reads results out in natural order.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : fft_seq_ctrl_if.master (control, load, butterfly and read ports)
// Parameters: N_LOG2 (log2 FFT length), BF_LAT (butterfly latency, >= 1).
// Build option FFT_BFP_SCALE_EN adds block-floating-point scaling
// (ovf_in, bf_scale, blk_exp).
// ---------------------------------------------------------------------------
module fft_seq_ctrl import fft_pkg::*; #(
   parameter int unsigned N_LOG2 = N_LOG2_DEF,
   parameter int unsigned BF_LAT = 2
) (
   input logic           clk,
   input logic           reset,
   fft_seq_ctrl_if.master bus
);

   localparam int unsigned N_PTS  = 2 ** N_LOG2;
   localparam int unsigned N_BFLY = N_PTS / 2;
   localparam int unsigned STW    = calc_sw(N_LOG2);
   localparam int unsigned JW     = calc_jw(N_LOG2);
   localparam int unsigned DW     = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

   localparam logic [N_LOG2-1:0] CNT_LAST   = N_LOG2'(N_PTS - 1);
   localparam logic [JW-1:0]     J_LAST     = JW'(N_BFLY - 1);
   localparam logic [STW-1:0]    STAGE_LAST = STW'(N_LOG2 - 1);
   localparam logic [DW-1:0]     D_LAST     = DW'(BF_LAT - 1);

   fft_seq_state_t    state, state_n;
   logic [N_LOG2-1:0] cnt, cnt_n;     // load index in LOAD, read index in OUTPUT
   logic [JW-1:0]     j, j_n;         // butterfly index within the stage
   logic [STW-1:0]    stg, stg_n;     // current stage
   logic [DW-1:0]     dcnt, dcnt_n;   // drain cycle counter

   logic [N_LOG2-1:0] ag_a;
   logic [N_LOG2-1:0] ag_b;
   logic [JW-1:0]     ag_tw;

   fft_bf_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
      .stage (stg),
      .j     (j),
      .a     (ag_a),
      .b     (ag_b),
      .tw    (ag_tw)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         j     <= '0;
         stg   <= '0;
         dcnt  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         j     <= j_n;
         stg   <= stg_n;
         dcnt  <= dcnt_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      j_n      = j;
      stg_n    = stg;
      dcnt_n   = dcnt;

      bus.busy        = (state != ST_IDLE);
      bus.fft_done    = 1'b0;
      bus.in_ready    = 1'b0;
      bus.in_wr_en    = 1'b0;
      bus.in_wr_addr  = '0;
      bus.bf_valid    = 1'b0;
      bus.bf_addr_a   = '0;
      bus.bf_addr_b   = '0;
      bus.bf_tw_addr  = '0;
      bus.stage       = stg;
      bus.out_rd_en   = 1'b0;
      bus.out_rd_addr = '0;
      bus.out_last    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_n = ST_LOAD;
               cnt_n   = '0;
               stg_n   = '0;
            end
         end

         ST_LOAD: begin
            bus.in_ready   = 1'b1;
            bus.in_wr_en   = bus.in_valid;
            bus.in_wr_addr = N_LOG2'(bitrev(32'(cnt), N_LOG2));
            if (bus.in_valid) begin
               if (cnt == CNT_LAST) begin
                  state_n = ST_COMPUTE;
                  cnt_n   = '0;
                  j_n     = '0;
                  stg_n   = '0;
               end else begin
                  cnt_n = cnt + N_LOG2'(1);
               end
            end
         end

         ST_COMPUTE: begin
            bus.bf_valid   = 1'b1;
            bus.bf_addr_a  = ag_a;
            bus.bf_addr_b  = ag_b;
            bus.bf_tw_addr = ag_tw;
            if (j == J_LAST) begin
               state_n = ST_DRAIN;
               j_n     = '0;
               dcnt_n  = '0;
            end else begin
               j_n = j + JW'(1);
            end
         end

         // The gap lets the last write-backs of this stage land before the
         // next stage reads them.
         ST_DRAIN: begin
            if (dcnt == D_LAST) begin
               dcnt_n = '0;
               if (stg == STAGE_LAST) begin
                  state_n = ST_OUTPUT;
                  cnt_n   = '0;
               end else begin
                  state_n = ST_COMPUTE;
                  stg_n   = stg + STW'(1);
               end
            end else begin
               dcnt_n = dcnt + DW'(1);
            end
         end

         ST_OUTPUT: begin
            bus.out_rd_addr = cnt;
            bus.out_rd_en   = bus.out_ready;
            bus.out_last    = bus.out_ready && (cnt == CNT_LAST);
            if (bus.out_ready) begin
               if (cnt == CNT_LAST) begin
                  state_n = ST_DONE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + N_LOG2'(1);
               end
            end
         end

         ST_DONE: begin
            bus.fft_done = 1'b1;
            state_n      = ST_IDLE;
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

`ifdef FFT_BFP_SCALE_EN
   logic           ovf_flag, ovf_flag_n;
   logic           scale_r, scale_n;
   logic [STW:0]   exp_r, exp_n;
   logic           ovf_any;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_flag <= 1'b0;
         scale_r  <= 1'b0;
         exp_r    <= '0;
      end else begin
         ovf_flag <= ovf_flag_n;
         scale_r  <= scale_n;
         exp_r    <= exp_n;
      end
   end

   // An overflow seen on the final drain cycle still counts for the stage,
   // so the hand-over uses the flag merged with the live ovf_in.
   always_comb begin
      ovf_flag_n = ovf_flag;
      scale_n    = scale_r;
      exp_n      = exp_r;
      ovf_any    = ovf_flag | bus.ovf_in;

      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               ovf_flag_n = 1'b0;
               scale_n    = 1'b0;
               exp_n      = '0;
            end
         end
         ST_COMPUTE: begin
            ovf_flag_n = ovf_any;
         end
         ST_DRAIN: begin
            if (state_n == ST_COMPUTE) begin
               scale_n    = ovf_any;
               ovf_flag_n = 1'b0;
               if (ovf_any) begin
                  exp_n = exp_r + (STW + 1)'(1);
               end
            end else if (state_n == ST_OUTPUT) begin
               // last-stage overflow has no following stage to scale
               scale_n    = 1'b0;
               ovf_flag_n = 1'b0;
            end else begin
               ovf_flag_n = ovf_any;
            end
         end
         default: begin
         end
      endcase
   end

   assign bus.bf_scale = scale_r;
   assign bus.blk_exp  = exp_r;
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_seq_ctrl
// Self-checking bench for fft_seq_ctrl (N_LOG2=3, BF_LAT=2). Checks a table
// of butterfly addresses on a standalone fft_bf_addr_gen, then runs whole
// frames with randomized handshakes against a cycle-indexed reference model.
// Define FFT_BFP_SCALE_EN to also check the block-floating-point outputs.
// ---------------------------------------------------------------------------
module tb_fft_seq_ctrl;

   localparam int unsigned N_LOG2    = 3;
   localparam int unsigned BF_LAT    = 2;
   localparam int unsigned NP        = 8;
   localparam int unsigned NB        = 4;
   localparam int unsigned STAGE_LEN = NB + BF_LAT;
   localparam int unsigned SPAN      = N_LOG2 * STAGE_LEN;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fft_seq_ctrl_if #(.N_LOG2(N_LOG2)) bus ();

   fft_seq_ctrl #(.N_LOG2(N_LOG2), .BF_LAT(BF_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [1:0] ag_stage;
   logic [1:0] ag_j;
   logic [2:0] ag_a;
   logic [2:0] ag_b;
   logic [1:0] ag_tw;

   fft_bf_addr_gen #(.N_LOG2(N_LOG2)) u_ag (
      .stage (ag_stage),
      .j     (ag_j),
      .a     (ag_a),
      .b     (ag_b),
      .tw    (ag_tw)
   );

   typedef struct {
      int unsigned stage;
      int unsigned j;
      int unsigned a;
      int unsigned b;
      int unsigned tw;
   } ag_vec_t;

   ag_vec_t     ag_tab [12];
   int unsigned load_order [NP] = '{0, 4, 2, 6, 1, 5, 3, 7};
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference butterfly addressing from plain arithmetic.
   function automatic void ref_bf(input int unsigned s, input int unsigned jj,
                                  output int unsigned a, output int unsigned b,
                                  output int unsigned tw);
      int unsigned half, pos, grp;
      half = 2 ** s;
      pos  = jj % half;
      grp  = jj / half;
      a    = grp * 2 * half + pos;
      b    = a + half;
      tw   = pos * (2 ** (N_LOG2 - 1 - s));
   endfunction

   // Number of set bits of mask below bit position s.
   function automatic int unsigned ones_below(input int unsigned mask, input int unsigned s);
      int unsigned c;
      c = 0;
      for (int unsigned i = 0; i < s; i++) begin
         c += (mask / (2 ** i)) % 2;
      end
      return c;
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // rdy_mode: 0 toggles out_ready 1,0,1..., 1 random, 2 always 1.
   // ovf_mask bit s pulses ovf_in once in stage s. stop_after>0 returns
   // mid-COMPUTE at that compute cycle index.
   task automatic run_frame(input int unsigned rdy_mode, input bit rand_valid,
                            input int unsigned ovf_mask, input int unsigned stop_after);
      int unsigned k, r, guard, s, o, ea, eb, et;
      int unsigned ovf_pos [N_LOG2];
      logic rdy, tog;

      for (int unsigned i = 0; i < N_LOG2; i++) ovf_pos[i] = $urandom_range(0, STAGE_LEN - 1);

      @(negedge clk);
      bus.start    = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = rbit();
      #1;
      check("idle_busy", bus.busy, 0);
      check("idle_in_ready", bus.in_ready, 0);
      check("idle_fft_done", bus.fft_done, 0);

      k = 0;
      guard = 0;
      while (k < NP && guard < 200) begin
         @(negedge clk);
         bus.start     = rbit();
         bus.in_valid  = rand_valid ? rbit() : 1'b1;
         bus.out_ready = rbit();
         #1;
         check("load_in_ready", bus.in_ready, 1);
         check("load_busy", bus.busy, 1);
         check("load_bf_valid", bus.bf_valid, 0);
         check("load_rd_en", bus.out_rd_en, 0);
         check("load_wr_en", bus.in_wr_en, bus.in_valid);
`ifdef FFT_BFP_SCALE_EN
         check("load_blk_exp", bus.blk_exp, 0);
`endif
         if (bus.in_valid) begin
            check("load_wr_addr", bus.in_wr_addr, load_order[k]);
            k++;
         end
         guard++;
      end
      if (k != NP) begin
         check("load_timeout", k, NP);
         return;
      end

      for (int unsigned t = 0; t < SPAN; t++) begin
         @(negedge clk);
         s = t / STAGE_LEN;
         o = t % STAGE_LEN;
         bus.start     = rbit();
         bus.in_valid  = rbit();
         bus.out_ready = rbit();
`ifdef FFT_BFP_SCALE_EN
         bus.ovf_in = ((ovf_mask / (2 ** s)) % 2 == 1) && (o == ovf_pos[s]);
`endif
         #1;
         if (stop_after != 0 && t == stop_after) return;
         check("comp_bf_valid", bus.bf_valid, (o < NB) ? 1 : 0);
         check("comp_stage", bus.stage, s);
         check("comp_in_ready", bus.in_ready, 0);
         check("comp_wr_en", bus.in_wr_en, 0);
         check("comp_busy", bus.busy, 1);
         check("comp_rd_en", bus.out_rd_en, 0);
         if (o < NB) begin
            ref_bf(s, o, ea, eb, et);
            check("comp_addr_a", bus.bf_addr_a, ea);
            check("comp_addr_b", bus.bf_addr_b, eb);
            check("comp_tw", bus.bf_tw_addr, et);
         end
`ifdef FFT_BFP_SCALE_EN
         check("comp_bf_scale", bus.bf_scale, (s > 0) ? (ovf_mask / (2 ** (s - 1))) % 2 : 0);
         check("comp_blk_exp", bus.blk_exp, ones_below(ovf_mask, s));
`endif
      end

      r = 0;
      guard = 0;
      tog = 1'b1;
      while (r < NP && guard < 200) begin
         @(negedge clk);
         rdy = (rdy_mode == 0) ? tog : (rdy_mode == 1) ? rbit() : 1'b1;
         tog = ~tog;
         bus.out_ready = rdy;
         bus.start     = rbit();
         bus.in_valid  = rbit();
`ifdef FFT_BFP_SCALE_EN
         bus.ovf_in = rbit();
`endif
         #1;
         check("out_rd_addr", bus.out_rd_addr, r);
         check("out_rd_en", bus.out_rd_en, rdy);
         check("out_last", bus.out_last, (rdy && r == NP - 1) ? 1 : 0);
         check("out_fft_done", bus.fft_done, 0);
         check("out_busy", bus.busy, 1);
         check("out_bf_valid", bus.bf_valid, 0);
         check("out_in_ready", bus.in_ready, 0);
`ifdef FFT_BFP_SCALE_EN
         check("out_blk_exp", bus.blk_exp, ones_below(ovf_mask, N_LOG2 - 1));
         check("out_bf_scale", bus.bf_scale, 0);
`endif
         if (rdy) r++;
         guard++;
      end
      if (r != NP) begin
         check("out_timeout", r, NP);
         return;
      end

      @(negedge clk);
      bus.start     = 1'b1;
      bus.out_ready = rbit();
`ifdef FFT_BFP_SCALE_EN
      bus.ovf_in = 1'b0;
`endif
      #1;
      check("done_pulse", bus.fft_done, 1);
      check("done_busy", bus.busy, 1);
      check("done_rd_en", bus.out_rd_en, 0);
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check("post_done_pulse", bus.fft_done, 0);
      check("post_done_busy", bus.busy, 0);
      @(negedge clk);
      #1;
      check("idle_after_busy", bus.busy, 0);
      check("idle_after_in_ready", bus.in_ready, 0);
`ifdef FFT_BFP_SCALE_EN
      check("idle_blk_exp_hold", bus.blk_exp, ones_below(ovf_mask, N_LOG2 - 1));
`endif
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_in_ready"}, bus.in_ready, 0);
      check({tag, "_wr_en"}, bus.in_wr_en, 0);
      check({tag, "_wr_addr"}, bus.in_wr_addr, 0);
      check({tag, "_bf_valid"}, bus.bf_valid, 0);
      check({tag, "_addr_a"}, bus.bf_addr_a, 0);
      check({tag, "_addr_b"}, bus.bf_addr_b, 0);
      check({tag, "_tw"}, bus.bf_tw_addr, 0);
      check({tag, "_stage"}, bus.stage, 0);
      check({tag, "_rd_en"}, bus.out_rd_en, 0);
      check({tag, "_rd_addr"}, bus.out_rd_addr, 0);
      check({tag, "_last"}, bus.out_last, 0);
      check({tag, "_done"}, bus.fft_done, 0);
`ifdef FFT_BFP_SCALE_EN
      check({tag, "_bf_scale"}, bus.bf_scale, 0);
      check({tag, "_blk_exp"}, bus.blk_exp, 0);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      ag_tab[0]  = '{0, 0, 0, 1, 0};
      ag_tab[1]  = '{0, 1, 2, 3, 0};
      ag_tab[2]  = '{0, 2, 4, 5, 0};
      ag_tab[3]  = '{0, 3, 6, 7, 0};
      ag_tab[4]  = '{1, 0, 0, 2, 0};
      ag_tab[5]  = '{1, 1, 1, 3, 2};
      ag_tab[6]  = '{1, 2, 4, 6, 0};
      ag_tab[7]  = '{1, 3, 5, 7, 2};
      ag_tab[8]  = '{2, 0, 0, 4, 0};
      ag_tab[9]  = '{2, 1, 1, 5, 1};
      ag_tab[10] = '{2, 2, 2, 6, 2};
      ag_tab[11] = '{2, 3, 3, 7, 3};

      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
`ifdef FFT_BFP_SCALE_EN
      bus.ovf_in    = 1'b0;
`endif
      ag_stage = '0;
      ag_j     = '0;
      #12;
      check_all_zero("rst");
      @(negedge clk);
      reset = 1'b0;

      for (int unsigned i = 0; i < 12; i++) begin
         ag_stage = 2'(ag_tab[i].stage);
         ag_j     = 2'(ag_tab[i].j);
         #1;
         check("ag_a", ag_a, ag_tab[i].a);
         check("ag_b", ag_b, ag_tab[i].b);
         check("ag_tw", ag_tw, ag_tab[i].tw);
      end

      // back-to-back load, out_ready toggling 1,0,1,...
      run_frame(0, 1'b0, 0, 0);

      // reset in stage 1 of COMPUTE, raised between clock edges
      run_frame(2, 1'b0, 0, 8);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_bf_valid", bus.bf_valid, 0);
      check("async_rst_busy", bus.busy, 0);
      check("async_rst_in_ready", bus.in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
`ifdef FFT_BFP_SCALE_EN
      bus.ovf_in = 1'b0;
`endif
      bus.start = 1'b0;
      #1;
      check_all_zero("post_rst");

      // overflow in stage 0 only
      run_frame(1, 1'b1, 1, 0);

      for (int unsigned f = 0; f < 4; f++) begin
         run_frame($urandom_range(0, 2), 1'b1, $urandom_range(0, 7), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
